alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Execute-stage ALU that consumes the 3-bit ALUControl code produced by the ALU decoder and returns a result plus zero flag for branch resolution.
- Single-cycle ops (ADD/SUB/AND/OR/SLL/SLT) complete in one cycle; MUL runs as an iterative shift-add multiplier.
- Valid/ready handshakes on both sides let the pipeline control stall during a multiply.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operands and ALUControl valid
- in_ready  output  1  block can accept a new operation
- ALUControl  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SLT, 111 reserved
- a  input  WIDTH  operand A (rs1)
- b  input  WIDTH  operand B (rs2/imm)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- zero  output  1  result == 0 (beq/bne use)
- busy  output  1  multiply in progress

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; in_ready=1, out_valid=0, busy=0, result=0, zero=1, internal accumulators cleared. Reset dominates every other input, including mid-multiply; the in-flight op is discarded with no output.
- States: IDLE, MUL, HOLD.
- IDLE: in_ready=1. An accept (in_valid & in_ready) at edge N latches a, b, ALUControl.
  - Non-MUL code: result registered at edge N; out_valid=1 from cycle N+1; go to HOLD.
  - MUL: go to MUL; busy=1.
- MUL: in_ready=0.
  - Multiplicand register shifts left one bit per cycle; multiplier register shifts right one bit per cycle.
  - Accumulator adds the multiplicand when multiplier bit0=1.
  - After exactly WIDTH iterations (edges N+1..N+WIDTH), result = low WIDTH bits of the product, out_valid=1, busy=0; go to HOLD.
  - Signed or unsigned interpretation gives identical low bits.
  - Latency: accept to out_valid = WIDTH+1 cycles.
- HOLD: in_ready=0. result, zero, and out_valid are held stable until out_ready=1. On that edge out_valid clears and state goes to IDLE.
  - New accept is possible the following cycle; no same-cycle result-drain plus new-accept.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the source must hold its request.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: a+b. SUB: a-b (two's complement wrap, e.g. 0-1 = all ones).
  - AND/OR: bitwise.
  - SLL: a << b[SHW-1:0]; upper bits of b are ignored.
  - SLT: signed compare; result 1 if $signed(a) < $signed(b), else 0.
  - 111: result 0, zero=1, single-cycle timing; never X.
- zero is registered together with result and always equals (result==0).

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: the MUL state exits on the first cycle where the remaining multiplier register is 0 (checked before adding). Latency is 1 + (index of highest set bit of b) + 1 cycles. b==0 gives result 0 with out_valid at N+2.
- Undefined: fixed WIDTH-iteration latency as described above.
- The result value is identical in both builds.

Test Plan:
- Reset, then ADD a=5, b=7 with out_ready=1 → out_valid at N+1, result=12, zero=0; in_ready returns to 1 the cycle after the drain.
- SUB a=3, b=3 → result=0, zero=1. SUB a=0, b=1 → result=0xFFFFFFFF. SLT a=0xFFFFFFFF, b=1 → result=1.
- MUL a=0x0001_0003, b=0x0000_0005 → result=0x0005_000F.
  - Early exit off: out_valid exactly 33 cycles after accept, busy high 32 cycles.
  - Early exit on: out_valid 4 cycles after accept.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles → result=2 and out_valid held stable; in_ready=0 and a second in_valid is ignored; drains when out_ready=1.
- SLL a=1, b=0x0000_0125 → result=0x20 (shift 5); ALUControl=111 → result=0, zero=1.
- Reset asserted 10 cycles into a MUL → the next edge gives IDLE, out_valid=0, busy=0, result=0. A following ADD 2+2 returns 4 with normal latency.

Source files
------------

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- operand/result bundle for the alu_seq execute-stage ALU.
//
// Signals:
//   in_valid   : operands and ALUControl are valid
//   in_ready   : ALU can accept a new operation
//   ALUControl : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 SLL,
//                110 SLT, 111 reserved (result 0)
//   a, b       : operands (rs1, rs2/imm)
//   out_valid  : result/zero are valid
//   out_ready  : consumer takes the result
//   result     : operation result
//   zero       : result == 0
//   busy       : iterative multiply in progress
//
// Modports:
//   master : pipeline side (drives operands, consumes result)
//   slave  : ALU side
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, ALUControl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, ALUControl, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- execute-stage ALU with an iterative shift-add multiplier.
//
// Single-cycle ops (ADD/SUB/AND/OR/SLL/SLT/reserved) register their result on
// the accepting edge. MUL iterates one multiplier bit per cycle. A result is
// held in HOLD until the consumer takes it.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : alu_seq_if.slave (valid/ready operand and result handshakes,
//           result, zero flag, busy)
//
// Parameters:
//   WIDTH : operand/result width, power of 2, >= 8
//   SHW   : shift-amount bits taken from b
//
// Build option:
//   ALU_MUL_EARLY_EXIT_EN : when defined, the multiply finishes on the
//   iteration that consumes the highest set multiplier bit (or immediately
//   for a zero multiplier) instead of always running WIDTH iterations.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg,   zero_next;
  logic [WIDTH-1:0] mcand_reg,  mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg,    acc_next;
  logic [SHW-1:0]   cnt_reg,    cnt_next;

  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_sum;
  logic             last_iter;

  // Single-cycle datapath; MUL and the reserved code fall to zero here.
  always_comb begin
    alu_out = '0;
    case (bus.ALUControl)
      OP_ADD:  alu_out = bus.a + bus.b;
      OP_SUB:  alu_out = bus.a - bus.b;
      OP_AND:  alu_out = bus.a & bus.b;
      OP_OR:   alu_out = bus.a | bus.b;
      OP_SLL:  alu_out = bus.a << bus.b[SHW-1:0];
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_out = '0;
    endcase
  end

  // One shift-add step; low WIDTH bits are sign-agnostic.
  assign addend  = mplier_reg[0] ? mcand_reg : '0;
  assign acc_sum = acc_reg + addend;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Stop once no set bits remain above the one being consumed now. A zero
  // multiplier therefore finishes on the first iteration with acc = 0.
  assign last_iter = (cnt_reg == SHW'(WIDTH - 1)) || (mplier_reg[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_reg == SHW'(WIDTH - 1));
`endif

  // Next-state and outputs.
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;

    bus.in_ready  = (state_reg == ST_IDLE);
    bus.out_valid = (state_reg == ST_HOLD);
    bus.busy      = (state_reg == ST_MUL);
    bus.result    = result_reg;
    bus.zero      = zero_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.ALUControl == OP_MUL) begin
            mcand_next  = bus.a;
            mplier_next = bus.b;
            acc_next    = '0;
            cnt_next    = '0;
            state_next  = ST_MUL;
          end else begin
            result_next = alu_out;
            zero_next   = (alu_out == '0);
            state_next  = ST_HOLD;
          end
        end
      end

      ST_MUL: begin
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        acc_next    = acc_sum;
        cnt_next    = cnt_reg + SHW'(1);
        if (last_iter) begin
          result_next = acc_sum;
          zero_next   = (acc_sum == '0);
          state_next  = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Drain only; a new operation is accepted from IDLE next cycle.
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// Expected results come from a behavioural model and pass through a
// scoreboard queue; latency expectations follow ALU_MUL_EARLY_EXIT_EN.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: r = av + bv;
      3'd1: r = av - bv;
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av * bv;
      3'd5: r = av << bv[4:0];
      3'd6: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [WIDTH-1:0] bv);
    int h;
    if (op != 3'd4) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    if (bv == '0) return 2;
    h = 0;
    for (int i = 0; i < WIDTH; i++) if (bv[i]) h = i;
    return h + 2;
`else
    h = bv[0];
    return WIDTH + 1 + h - h;
`endif
  endfunction

  // Drive one op with out_ready=1, check latency, busy time, result, drain.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int cyc, bcyc, lat;
    logic [WIDTH-1:0] exp_r;
    lat = exp_latency(op, bv);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.a          = av;
    bus.b          = bv;
    sb.push_back(model(op, av, bv));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc  = 1;
    bcyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (bus.busy) bcyc++;
      @(posedge clk); #1;
      cyc++;
    end
    exp_r = sb.pop_front();
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_busy_cycles"}, 64'(bcyc), 64'(lat - 1));
    chk({name, "_result"}, 64'(bus.result), 64'(exp_r));
    chk({name, "_zero"}, 64'(bus.zero), 64'(exp_r == '0));
    chk({name, "_in_ready_hold"}, 64'(bus.in_ready), 64'(0));
    $display("op %s ctrl=%0d a=0x%08h b=0x%08h -> result=0x%08h zero=%0b lat=%0d",
             name, op, av, bv, bus.result, bus.zero, cyc);
    @(posedge clk); #1;
    chk({name, "_drained"}, 64'(bus.out_valid), 64'(0));
    chk({name, "_in_ready_back"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] exp_r;
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'd0;
    bus.a          = '0;
    bus.b          = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_zero", 64'(bus.zero), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("add_5_7",   3'd0, 32'd5,          32'd7);
    run_op("sub_3_3",   3'd1, 32'd3,          32'd3);
    run_op("sub_0_1",   3'd1, 32'd0,          32'd1);
    run_op("slt_m1_1",  3'd6, 32'hFFFF_FFFF,  32'd1);
    run_op("slt_1_m1",  3'd6, 32'd1,          32'hFFFF_FFFF);
    run_op("and",       3'd2, 32'hF0F0_1234,  32'h0FF0_FF00);
    run_op("or",        3'd3, 32'hF000_0001,  32'h0000_1000);
    run_op("mul",       3'd4, 32'h0001_0003,  32'h0000_0005);
    run_op("mul_b0",    3'd4, 32'h1234_5678,  32'h0000_0000);
    run_op("mul_msb",   3'd4, 32'h0000_0003,  32'h8000_0001);
    run_op("sll_125",   3'd5, 32'd1,          32'h0000_0125);
    run_op("rsvd",      3'd7, 32'hDEAD_BEEF,  32'h1234_5678);

    // Backpressure: result held while out_ready=0, second request ignored.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'd0;
    bus.a          = 32'd1;
    bus.b          = 32'd1;
    sb.push_back(model(3'd0, 32'd1, 32'd1));
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'd9;
      bus.b        = 32'd9;
      chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_result", 64'(bus.result), 64'(2));
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    exp_r = sb.pop_front();
    chk("bp_drain_result", 64'(bus.result), 64'(exp_r));
    $display("op backpressure add 1+1 -> result=0x%08h held 5 cycles", bus.result);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drained", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("bp_no_phantom", 64'(bus.out_valid), 64'(0));

    // Reset in the middle of a multiply discards it.
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'd4;
    bus.a          = 32'h0000_0077;
    bus.b          = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mrst_busy_before", 64'(bus.busy), 64'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mrst_busy", 64'(bus.busy), 64'(0));
    chk("mrst_result", 64'(bus.result), 64'(0));
    chk("mrst_zero", 64'(bus.zero), 64'(1));
    chk("mrst_in_ready", 64'(bus.in_ready), 64'(1));
    $display("op reset mid-multiply -> out_valid=%0b busy=%0b", bus.out_valid, bus.busy);
    reset = 1'b1;
    @(posedge clk); #1;
    run_op("add_2_2", 3'd0, 32'd2, 32'd2);

    // A handful of random operations across all codes.
    for (int i = 0; i < 10; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
